// File: rtl/harvard_run_ctrl.sv
// Load-and-run sequencer for the Harvard core: clears core memory, streams a program in,
// primes the core with a reset pulse, runs it to a halt condition and captures the accumulator.
module harvard_run_ctrl #(
    parameter int ADDR_WIDTH   = 6,
    parameter int WORD_WIDTH   = 37,
    parameter int MEM_DEPTH    = 64,
    parameter int PRIME_CYCLES = 2,
    parameter int RUN_CYCLES   = 200,
    parameter int HALT_PC      = 80
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  cpu_reset,
    output logic                  cpu_wr,
    output logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [WORD_WIDTH-1:0] cpu_data,
    input  logic [31:0]           cpu_pc,
    input  logic [31:0]           cpu_acc,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [15:0]           run_cycles,
    output logic [31:0]           result
);
    localparam int PW = $clog2(PRIME_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, PRIME, RUN, DONE, ERROR} state_t;

    state_t                state_q, state_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  cpu_wr_q, cpu_wr_d;
    logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
    logic [WORD_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
    logic [15:0]           run_cycles_q, run_cycles_d;
    logic [31:0]           result_q, result_d;
    logic [PW-1:0]         prime_cnt_q, prime_cnt_d;
    logic                  hs;

    assign s_ready = (state_q == LOAD);
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d        = state_q;
        cpu_reset_d    = cpu_reset_q;
        cpu_wr_d       = cpu_wr_q;
        cpu_addr_d     = cpu_addr_q;
        cpu_data_d     = cpu_data_q;
        words_loaded_d = words_loaded_q;
        run_cycles_d   = run_cycles_q;
        result_d       = result_q;
        prime_cnt_d    = prime_cnt_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                cpu_reset_d = 1'b1;
                cpu_wr_d    = 1'b0;
                if (start) begin
                    state_d      = CLEAR;
                    cpu_reset_d  = 1'b0;
                    cpu_wr_d     = 1'b1;
                    cpu_addr_d   = '0;
                    cpu_data_d   = '0;
                    run_cycles_d = '0;
                end
            end
            CLEAR: begin
                cpu_reset_d = 1'b0;
                cpu_data_d  = '0;
                if (cpu_addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
                    state_d        = LOAD;
                    cpu_wr_d       = 1'b0;
                    words_loaded_d = '0;
                end else begin
                    cpu_wr_d   = 1'b1;
                    cpu_addr_d = cpu_addr_q + 1'b1;
                end
            end
            LOAD: begin
                cpu_wr_d = 1'b0;
                if (hs) begin
                    cpu_wr_d       = 1'b1;
                    cpu_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
                    cpu_data_d     = s_data;
                    words_loaded_d = words_loaded_q + 1'b1;
                    if (s_last) begin
                        state_d     = PRIME;
                        prime_cnt_d = '0;
                    end else if (words_loaded_q == (ADDR_WIDTH+1)'(MEM_DEPTH - 1)) begin
                        state_d = ERROR;
                    end
                end
            end
            PRIME: begin
                // First PRIME cycle still presents the final write with the core out of reset.
                cpu_wr_d = 1'b0;
                if (prime_cnt_q == PW'(PRIME_CYCLES)) begin
                    state_d      = RUN;
                    cpu_reset_d  = 1'b0;
                    run_cycles_d = '0;
                end else begin
                    prime_cnt_d = prime_cnt_q + 1'b1;
                    cpu_reset_d = 1'b1;
                end
            end
            RUN: begin
                cpu_reset_d = 1'b0;
                cpu_wr_d    = 1'b0;
                if (cpu_pc >= 32'(HALT_PC) || run_cycles_q == 16'(RUN_CYCLES - 1)) begin
                    state_d     = DONE;
                    result_d    = cpu_acc;
                    cpu_reset_d = 1'b1;
                end else begin
                    run_cycles_d = run_cycles_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d     = IDLE;
            cpu_reset_d = 1'b1;
            cpu_wr_d    = 1'b0;
        end
        busy_d  = (state_d == CLEAR) || (state_d == LOAD) || (state_d == PRIME) || (state_d == RUN);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cpu_reset_q    <= 1'b1;
            cpu_wr_q       <= 1'b0;
            cpu_addr_q     <= '0;
            cpu_data_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            run_cycles_q   <= '0;
            result_q       <= '0;
            prime_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            cpu_reset_q    <= cpu_reset_d;
            cpu_wr_q       <= cpu_wr_d;
            cpu_addr_q     <= cpu_addr_d;
            cpu_data_q     <= cpu_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
            run_cycles_q   <= run_cycles_d;
            result_q       <= result_d;
            prime_cnt_q    <= prime_cnt_d;
        end
    end

    assign cpu_reset    = cpu_reset_q;
    assign cpu_wr       = cpu_wr_q;
    assign cpu_addr     = cpu_addr_q;
    assign cpu_data     = cpu_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;
    assign run_cycles   = run_cycles_q;
    assign result       = result_q;
endmodule

// File: tb/tb_harvard_run_ctrl.sv
// Directed bench for harvard_run_ctrl with a small behavioural Harvard core attached.
module tb_harvard_run_ctrl;
    localparam int AW = 6;
    localparam int WW = 37;
    localparam logic [4:0] OP_MOVI = 5'h01;
    localparam logic [4:0] OP_SUMI = 5'h02;
    localparam logic [4:0] OP_JUMP = 5'h03;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0;
    logic          s_valid = 1'b0, s_last = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready, cpu_reset, cpu_wr, busy, done, error;
    logic [AW-1:0] cpu_addr;
    logic [WW-1:0] cpu_data;
    logic [31:0]   cpu_pc, cpu_acc, result;
    logic [AW:0]   words_loaded;
    logic [15:0]   run_cycles;

    int n_vec = 0;
    int n_err = 0;

    harvard_run_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cpu_reset(cpu_reset), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_pc(cpu_pc), .cpu_acc(cpu_acc), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded), .run_cycles(run_cycles), .result(result)
    );

    always #5 clk = ~clk;

    // Minimal core: write port, reset of PC/ACC, and MOVI/SUMI/JUMP execution.
    logic [WW-1:0] mem [64];
    logic [31:0]   pc_r, acc_r;
    logic [WW-1:0] ins;
    assign ins     = mem[pc_r[5:0]];
    assign cpu_pc  = pc_r;
    assign cpu_acc = acc_r;
    always @(posedge clk) begin
        if (cpu_wr) mem[cpu_addr] <= cpu_data;
        if (cpu_reset) begin
            pc_r  <= 32'd0;
            acc_r <= 32'd0;
        end else if (!cpu_wr) begin
            case (ins[36:32])
                OP_MOVI: begin acc_r <= ins[31:0];         pc_r <= pc_r + 1; end
                OP_SUMI: begin acc_r <= acc_r + ins[31:0]; pc_r <= pc_r + 1; end
                OP_JUMP: pc_r <= ins[31:0];
                default: pc_r <= pc_r + 1;
            endcase
        end
    end

    function automatic logic [WW-1:0] wd(input logic [4:0] op, input logic [31:0] v);
        return {op, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_one(input logic [WW-1:0] w, input logic last);
        s_valid = 1'b1; s_data = w; s_last = last;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset got %b want 1", cpu_reset); end
        n_vec++; if (cpu_wr !== 1'b0 || s_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready got %b/%b want 0/0", cpu_wr, s_ready); end
        n_vec++; if (result !== 32'd0 || words_loaded !== '0 || run_cycles !== 16'd0) begin n_err++; $display("FAIL rst_counters got %0d/%0d/%0d want 0/0/0", result, words_loaded, run_cycles); end
        n_vec++; if ({busy, done, error} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {busy, done, error}); end
        reset_n = 1'b1;
        tick(); tick();
        n_vec++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || cpu_wr !== 1'b0) begin n_err++; $display("FAIL rst_stay_idle got rst=%b busy=%b wr=%b want 1 0 0", cpu_reset, busy, cpu_wr); end
    endtask

    task automatic test_async_reset();
        launch();
        repeat (66) tick();
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_load got s_ready=%b want 1", s_ready); end
        reset_n = 1'b0;
        #2;
        n_vec++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || cpu_addr !== '0) begin
            n_err++; $display("FAIL areset_immediate got rst=%b busy=%b rdy=%b addr=%0d want 1 0 0 0", cpu_reset, busy, s_ready, cpu_addr);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_clear_sweep();
        launch();
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (cpu_wr !== 1'b1 || cpu_addr !== AW'(i) || cpu_data !== '0 || busy !== 1'b1 || cpu_reset !== 1'b0) begin
                n_err++; $display("FAIL clear_step%0d got wr=%b addr=%0d data=%0h busy=%b want 1 %0d 0 1", i, cpu_wr, cpu_addr, cpu_data, busy, i);
            end
            tick();
        end
        n_vec++; if (s_ready !== 1'b1 || cpu_wr !== 1'b0 || words_loaded !== '0) begin
            n_err++; $display("FAIL clear_to_load got rdy=%b wr=%b wl=%0d want 1 0 0", s_ready, cpu_wr, words_loaded);
        end
    endtask

    task automatic test_load_backpressure();
        logic [6:0]    pat;
        logic [WW-1:0] prog [3];
        int k;
        pat = 7'b1010010;
        prog[0] = wd(OP_MOVI, 32'd5);
        prog[1] = wd(OP_SUMI, 32'd7);
        prog[2] = wd(OP_JUMP, 32'd80);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            s_valid = pat[i];
            s_data  = pat[i] ? prog[k] : '0;
            s_last  = pat[i] && (k == 2);
            tick();
            s_valid = 1'b0; s_last = 1'b0;
            n_vec++;
            if (pat[i]) begin
                if (cpu_wr !== 1'b1 || cpu_addr !== AW'(k) || cpu_data !== prog[k] || words_loaded !== (AW+1)'(k + 1)) begin
                    n_err++; $display("FAIL load_hs%0d got wr=%b addr=%0d data=%0h wl=%0d want 1 %0d %0h %0d", k, cpu_wr, cpu_addr, cpu_data, words_loaded, k, prog[k], k + 1);
                end
                k++;
            end else if (cpu_wr !== 1'b0 || words_loaded !== (AW+1)'(k)) begin
                n_err++; $display("FAIL load_gap%0d got wr=%b wl=%0d want 0 %0d", i, cpu_wr, words_loaded, k);
            end
        end
        n_vec++; if (words_loaded !== 7'd3 || s_ready !== 1'b0) begin n_err++; $display("FAIL load_total got wl=%0d rdy=%b want 3 0", words_loaded, s_ready); end
    endtask

    task automatic test_run_halt();
        tick();
        n_vec++; if (cpu_reset !== 1'b1 || cpu_wr !== 1'b0) begin n_err++; $display("FAIL prime_c1 got rst=%b wr=%b want 1 0", cpu_reset, cpu_wr); end
        tick();
        n_vec++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL prime_c2 got rst=%b want 1", cpu_reset); end
        tick();
        n_vec++; if (cpu_reset !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL run_entry got rst=%b busy=%b want 0 1", cpu_reset, busy); end
        for (int i = 0; i < 50 && !done; i++) tick();
        n_vec++; if (done !== 1'b1 || result !== 32'd12) begin n_err++; $display("FAIL run_result got done=%b result=%0d want 1 12", done, result); end
        n_vec++; if (run_cycles !== 16'd3 || cpu_reset !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL run_halt_state got cyc=%0d rst=%b busy=%b want 3 1 0", run_cycles, cpu_reset, busy);
        end
    endtask

    task automatic test_overflow();
        launch();
        n_vec++; if (done !== 1'b0 || run_cycles !== 16'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL restart_clears got done=%b cyc=%0d busy=%b want 0 0 1", done, run_cycles, busy);
        end
        repeat (64) tick();
        s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 64; i++) begin
            s_data = wd(5'h0, 32'(i));
            if (i == 63) begin
                n_vec++; if (s_ready !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL ovf_before got rdy=%b err=%b want 1 0", s_ready, error); end
            end
            tick();
        end
        n_vec++; if (error !== 1'b1 || s_ready !== 1'b0 || words_loaded !== 7'd64) begin
            n_err++; $display("FAIL ovf_error got err=%b rdy=%b wl=%0d want 1 0 64", error, s_ready, words_loaded);
        end
        n_vec++; if (cpu_wr !== 1'b1 || cpu_addr !== 6'd63 || cpu_data !== wd(5'h0, 32'd63)) begin
            n_err++; $display("FAIL ovf_last_write got wr=%b addr=%0d data=%0h want 1 63 3f", cpu_wr, cpu_addr, cpu_data);
        end
        s_data = wd(5'h0, 32'd64);
        tick();
        s_valid = 1'b0;
        n_vec++; if (cpu_wr !== 1'b0 || words_loaded !== 7'd64 || error !== 1'b1) begin
            n_err++; $display("FAIL ovf_65th got wr=%b wl=%0d err=%b want 0 64 1", cpu_wr, words_loaded, error);
        end
    endtask

    task automatic test_abort();
        launch();
        n_vec++; if (error !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL err_restart got err=%b busy=%b want 0 1", error, busy); end
        repeat (64) tick();
        send_one(wd(OP_JUMP, 32'd0), 1'b1);
        repeat (8) tick();
        n_vec++; if (busy !== 1'b1 || cpu_reset !== 1'b0) begin n_err++; $display("FAIL abort_pre got busy=%b rst=%b want 1 0", busy, cpu_reset); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1 || s_ready !== 1'b0 || result !== 32'd12) begin
            n_err++; $display("FAIL abort_idle got busy=%b done=%b rst=%b rdy=%b result=%0d want 0 0 1 0 12", busy, done, cpu_reset, s_ready, result);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_vec++; if (busy !== 1'b0 || cpu_wr !== 1'b0) begin n_err++; $display("FAIL start_abort got busy=%b wr=%b want 0 0", busy, cpu_wr); end
    endtask

    task automatic test_timeout();
        launch();
        repeat (64) tick();
        send_one(wd(OP_JUMP, 32'd0), 1'b1);
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if (cpu_wr !== 1'b0 || busy !== 1'b1 || cpu_reset !== 1'b0) begin
            n_err++; $display("FAIL start_ignored got wr=%b busy=%b rst=%b want 0 1 0", cpu_wr, busy, cpu_reset);
        end
        for (int i = 0; i < 300 && !done; i++) tick();
        n_vec++; if (done !== 1'b1 || run_cycles !== 16'd199 || result !== 32'd0) begin
            n_err++; $display("FAIL timeout got done=%b cyc=%0d result=%0d want 1 199 0", done, run_cycles, result);
        end
        tick();
        n_vec++; if (done !== 1'b1 || run_cycles !== 16'd199 || cpu_reset !== 1'b1) begin
            n_err++; $display("FAIL done_hold got done=%b cyc=%0d rst=%b want 1 199 1", done, run_cycles, cpu_reset);
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_clear_sweep();
        test_load_backpressure();
        test_run_halt();
        test_overflow();
        test_abort();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/harvard_run_ctrl.md
# harvard_run_ctrl

Load-and-run sequencer for the Harvard processor core. It clears the core's 64-entry program/data memory and streams a program into it over a valid/ready port. It then restarts the core, lets it execute until a halt condition, and captures the accumulator as the result. It sits between the testbench or host loader and the core's `wr`/`address`/`data_in`/`reset` pins, and replaces hand-driven write loops.

## Interface
- `ADDR_WIDTH`, 6: core memory address width.
- `WORD_WIDTH`, 37: core load word, `{opcode[4:0], operand[31:0]}`.
- `MEM_DEPTH`, 64: number of core memory entries cleared and loadable.
- `PRIME_CYCLES`, 2: cycles the core is held in reset before a run.
- `RUN_CYCLES`, 200: maximum execution cycles per run.
- `HALT_PC`, 80: core PC value treated as program end.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; honoured only in IDLE, DONE or ERROR.
- `abort`  in  1  return to IDLE from any state; has priority over `start`.
- `s_valid`  in  1  program word valid.
- `s_ready`  out  1  controller accepts a word.
- `s_data`  in  WORD_WIDTH  program word.
- `s_last`  in  1  marks the final program word.
- `cpu_reset`  out  1  to core `reset`, active-high.
- `cpu_wr`  out  1  to core `wr`.
- `cpu_addr`  out  ADDR_WIDTH  to core `address`.
- `cpu_data`  out  WORD_WIDTH  to core `data_in`.
- `cpu_pc`  in  32  from core `pc_debug`.
- `cpu_acc`  in  32  from core `data_out`.
- `busy`  out  1  high in CLEAR, LOAD, PRIME and RUN.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERROR, which is entered on a load overflow.
- `words_loaded`  out  ADDR_WIDTH+1  count of words accepted in the current load.
- `run_cycles`  out  16  cycles spent in RUN during the last run.
- `result`  out  32  `cpu_acc` captured on entry to DONE.

## Operation
- States: IDLE, CLEAR, LOAD, PRIME, RUN, DONE, ERROR.
- All outputs except `s_ready` are registered. `s_ready` = (state == LOAD).
- Reset (`reset_n` low) puts the block in IDLE with these values:
  - `cpu_reset` = 1.
  - `cpu_wr`, `cpu_addr`, `cpu_data` = 0.
  - `busy`, `done`, `error` = 0.
  - `words_loaded`, `run_cycles`, `result` = 0.
- IDLE: `cpu_reset` = 1 and `cpu_wr` = 0. `start` moves to CLEAR.
- CLEAR:
  - `cpu_reset` = 0, `cpu_wr` = 1, `cpu_data` = 0.
  - `cpu_addr` steps 0 to MEM_DEPTH-1, one address per cycle.
  - After the cycle writing MEM_DEPTH-1, move to LOAD with `cpu_wr` = 0 and `words_loaded` = 0.
- LOAD:
  - On a handshake (`s_valid` and `s_ready`): `cpu_wr` = 1, `cpu_addr` = `words_loaded[ADDR_WIDTH-1:0]`, `cpu_data` = `s_data`, `words_loaded` increments.
  - Without a handshake: `cpu_wr` = 0.
  - A handshake with `s_last` moves to PRIME.
  - A handshake that brings `words_loaded` to MEM_DEPTH without `s_last` moves to ERROR. No further word is accepted.
- PRIME: `cpu_wr` = 0 and `cpu_reset` = 1 for PRIME_CYCLES cycles, then move to RUN. This clears the core's PC and accumulator; core memory is retained.
- RUN:
  - `cpu_reset` = 0, `cpu_wr` = 0. `run_cycles` starts at 0 and increments each cycle.
  - Halt when `cpu_pc` ≥ HALT_PC or when `run_cycles` reaches RUN_CYCLES-1.
  - On halt: `result` ← `cpu_acc`, `cpu_reset` ← 1, move to DONE.
  - `run_cycles` holds its final value.
- DONE and ERROR: `cpu_reset` = 1. `start` moves to CLEAR, clears `done`/`error` and zeroes `run_cycles`. `result` is held until the next DONE.
- `abort` moves to IDLE at the next edge from any state:
  - `cpu_reset` = 1, `cpu_wr` = 0, `done` = `error` = 0.
  - `result` is kept.
- `start` is ignored while `busy` is high. A simultaneous `start` and `abort` resolves as `abort`.
- Zero-length programs are impossible: the first accepted word may carry `s_last`, giving a one-word program.

## Timing
- `start` sampled at edge E0 → `cpu_wr` = 1 with `cpu_addr` = 0 after E0. `cpu_addr` = 63 after E63.
- First `s_ready` appears after E64.
- A handshake at edge Ek → the core write is presented during the cycle after Ek and committed by the core at Ek+1.
- `s_last` handshake at Ek → `cpu_reset` = 1 after Ek+1, for PRIME_CYCLES cycles.
- Halt detected at edge Eh → `result`, `done` and `cpu_reset` = 1 are all visible after Eh.
- `reset_n` asserted mid-LOAD or mid-RUN → the IDLE values above take effect immediately, without waiting for a clock edge.

## Test plan
- Reset: hold `reset_n` = 0 → `cpu_reset` = 1, `cpu_wr` = 0, `s_ready` = 0, `result` = 0.
  - Release `reset_n` → stays in IDLE.
- Clear sweep: pulse `start` → exactly 64 consecutive `cpu_wr` cycles, `cpu_addr` 0..63, `cpu_data` = 0.
  - Then `s_ready` = 1.
- Load with backpressure: send 3 words (MOVI 5, SUMI 7, JUMP 80, last on word 3) with `s_valid` gaps.
  - Required: writes to addresses 0, 1, 2 only on handshake cycles, and `words_loaded` = 3.
- Run and halt: continue the load scenario with the core attached.
  - Required: PRIME lasts 2 cycles, the run halts on `cpu_pc` = 80, and `result` = 12 with `done` = 1.
- Overflow: stream 64 words with no `s_last`.
  - Required: `s_ready` drops after word 64, `error` = 1, and a 65th `s_valid` is not accepted.
- Abort and timeout:
  - `abort` mid-RUN → IDLE next edge, `done` = 0.
  - Program looping forever → DONE with `run_cycles` = 199.
